// File: rtl/video_burst_reader.sv
// Burst-to-single-word read converter for the video row preload port.
// Issues pipelined SDRAM reads under a credit limit and streams returned words in address order.
module video_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 23,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 9,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_request,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [LEN_WIDTH-1:0]  rd_burst_length,
  output logic                  rd_available,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] OccMax = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFlush} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [LEN_WIDTH-1:0]  pend_len_q, pend_len_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  deliver_left_q, deliver_left_d;
  logic [CntW-1:0]       in_flight_q, in_flight_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic                  rd_available_q, rd_available_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic            abort;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CntW:0]   occupancy;

  // Words in flight plus words buffered form the credit pool, so the FIFO can never overflow.
  always_comb begin
    abort       = rd_request && ((state_q == StIssue) || (state_q == StDrain));
    occupancy   = {1'b0, in_flight_q} + {1'b0, count_q};
    mem_request = (state_q == StIssue) && (issue_left_q != '0) && (occupancy < OccMax) && !abort;
    accept      = mem_request && mem_ready;
    push        = mem_valid && (state_q != StFlush) && !abort;
    pop         = (count_q != '0) && (state_q != StFlush) && !abort;
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = mem_data;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    in_flight_d = in_flight_q;
    if (accept && !mem_valid) begin
      in_flight_d = in_flight_q + CntW'(1);
    end else if (!accept && mem_valid && (in_flight_q != '0)) begin
      in_flight_d = in_flight_q - CntW'(1);
    end

    rd_available_d = pop;
    rd_data_d      = pop ? fifo_q[rd_ptr_q] : rd_data_q;
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = accept ? addr_q + ADDR_WIDTH'(1) : addr_q;
    issue_left_d   = accept ? issue_left_q - LEN_WIDTH'(1) : issue_left_q;
    deliver_left_d = pop ? deliver_left_q - LEN_WIDTH'(1) : deliver_left_q;
    pend_addr_d    = pend_addr_q;
    pend_len_d     = pend_len_q;

    unique case (state_q)
      StIdle: begin
        if (rd_request && (rd_burst_length != '0)) begin
          state_d        = StIssue;
          addr_d         = rd_address;
          issue_left_d   = rd_burst_length;
          deliver_left_d = rd_burst_length;
        end
      end
      StIssue: begin
        if (rd_request) begin
          state_d     = StFlush;
          pend_addr_d = rd_address;
          pend_len_d  = rd_burst_length;
        end else if (accept && (issue_left_q == LEN_WIDTH'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (rd_request) begin
          state_d     = StFlush;
          pend_addr_d = rd_address;
          pend_len_d  = rd_burst_length;
        end else if (deliver_left_q == '0) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (rd_request) begin
          pend_addr_d = rd_address;
          pend_len_d  = rd_burst_length;
        end
        // Last-arriving request wins even on the exit cycle.
        if (in_flight_q == '0) begin
          state_d        = (pend_len_d == '0) ? StIdle : StIssue;
          addr_d         = pend_addr_d;
          issue_left_d   = pend_len_d;
          deliver_left_d = pend_len_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      pend_addr_q    <= '0;
      pend_len_q     <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      in_flight_q    <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_available_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      pend_addr_q    <= pend_addr_d;
      pend_len_q     <= pend_len_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      in_flight_q    <= in_flight_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_available_q <= rd_available_d;
      rd_data_q      <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign rd_available = rd_available_q;
  assign rd_data      = rd_data_q;
  assign busy         = (state_q != StIdle);
  assign mem_address  = addr_q;

endmodule

// File: tb/tb_video_burst_reader.sv
// Self-checking bench for video_burst_reader: random-latency SDRAM model plus an
// address-ordered expected word stream per burst.
module tb_video_burst_reader;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_request = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [LW-1:0] rd_burst_length = '0;
  logic          rd_available;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          mem_request;
  logic [AW-1:0] mem_address;
  logic          mem_ready = 1'b0;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_data = '0;

  int n_vec = 0;
  int n_err = 0;

  video_burst_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .FIFO_DEPTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_request     (rd_request),
    .rd_address     (rd_address),
    .rd_burst_length(rd_burst_length),
    .rd_available   (rd_available),
    .rd_data        (rd_data),
    .busy           (busy),
    .mem_request    (mem_request),
    .mem_address    (mem_address),
    .mem_ready      (mem_ready),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data)
  );

  always #5 clk = ~clk;

  // Memory contents: every address holds a distinct word.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a[8:0], ~a};
  endfunction

  // SDRAM model: in-order returns, latency lat_min..lat_max, random acceptance.
  logic [AW-1:0] pend_a[$];
  longint        pend_due[$];
  longint        cyc = 0;
  longint        last_due = 0;
  int            lat_min = 1;
  int            lat_max = 1;
  int            ready_pct = 100;

  initial begin
    longint due;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend_a.delete();
        pend_due.delete();
        last_due = 0;
      end else if (mem_request && mem_ready) begin
        due = cyc + longint'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        pend_a.push_back(mem_address);
        pend_due.push_back(due);
        last_due = due;
      end
      @(posedge clk);
      #1;
      cyc++;
      mem_valid = 1'b0;
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        mem_valid = 1'b1;
        mem_data  = word_of(pend_a.pop_front());
        void'(pend_due.pop_front());
      end
      mem_ready = ($urandom_range(99, 0) < ready_pct);
    end
  end

  // Observation of delivered words, accepted addresses and occupancy.
  logic [DW-1:0] got_q[$];
  logic [AW-1:0] iss_q[$];
  int acc_total, del_total, max_out;
  bit saw_req, saw_avail, saw_busy, busy_prev;
  int mcyc = 0;
  int last_avail_cyc, busy_fall_cyc;

  initial begin
    forever begin
      @(negedge clk);
      mcyc++;
      if (rd_available === 1'b1) begin
        got_q.push_back(rd_data);
        del_total++;
        last_avail_cyc = mcyc;
      end
      if (acc_total - del_total > max_out) max_out = acc_total - del_total;
      if (mem_request === 1'b1 && mem_ready && reset) begin
        iss_q.push_back(mem_address);
        acc_total++;
      end
      if (mem_request === 1'b1) saw_req = 1'b1;
      if (rd_available === 1'b1) saw_avail = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
      if (busy_prev && busy === 1'b0) busy_fall_cyc = mcyc;
      busy_prev = (busy === 1'b1);
    end
  end

  task automatic clear_mon();
    got_q.delete();
    iss_q.delete();
    acc_total = 0;
    del_total = 0;
    max_out = 0;
    saw_req = 1'b0;
    saw_avail = 1'b0;
    saw_busy = 1'b0;
    last_avail_cyc = -1;
    busy_fall_cyc = -1;
  endtask

  task automatic request(input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(posedge clk);
    #1;
    rd_request = 1'b1;
    rd_address = a;
    rd_burst_length = l;
    @(posedge clk);
    #1;
    rd_request = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_words(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({rd_available, busy, mem_request, mem_address, rd_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got avail=%b busy=%b req=%b addr=%h data=%h required all 0",
               rd_available, busy, mem_request, mem_address, rd_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [DW-1:0] act, exp_w;
    clear_mon();
    lat_min = 3; lat_max = 3; ready_pct = 100;
    repeat (2) @(posedge clk);
    request(23'h000100, 9'd80);
    wait_idle(3000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_timeout got busy=%b required 0", busy); end
    n_vec++;
    if (got_q.size() != 80) begin
      n_err++;
      $display("FAIL basic_count got %0d required 80", got_q.size());
    end
    for (int i = 0; i < 80; i++) begin
      exp_w = word_of(23'h000100 + AW'(i));
      act = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (act !== exp_w) begin
        n_err++;
        $display("FAIL basic_word[%0d] got %h required %h", i, act, exp_w);
      end
    end
    n_vec++;
    if (busy_fall_cyc != last_avail_cyc + 1) begin
      n_err++;
      $display("FAIL basic_busy_drop got cycle %0d required %0d", busy_fall_cyc,
               last_avail_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] act_a, exp_a;
    logic [DW-1:0] act, exp_w;
    clear_mon();
    lat_min = 1; lat_max = 4; ready_pct = 100;
    request(23'h7FFFFE, 9'd4);
    wait_idle(1000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wrap_timeout got busy=%b required 0", busy); end
    n_vec++;
    if (iss_q.size() != 4 || got_q.size() != 4) begin
      n_err++;
      $display("FAIL wrap_count got %0d issues %0d words required 4 and 4", iss_q.size(),
               got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = 23'h7FFFFE + AW'(i);
      act_a = (i < iss_q.size()) ? iss_q[i] : 'x;
      n_vec++;
      if (act_a !== exp_a) begin
        n_err++;
        $display("FAIL wrap_addr[%0d] got %h required %h", i, act_a, exp_a);
      end
      exp_w = word_of(exp_a);
      act = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (act !== exp_w) begin
        n_err++;
        $display("FAIL wrap_word[%0d] got %h required %h", i, act, exp_w);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [AW-1:0] base;
    int len;
    logic [DW-1:0] act, exp_w;
    lat_min = 1; lat_max = 8; ready_pct = 50;
    for (int k = 0; k < 3; k++) begin
      clear_mon();
      base = AW'($urandom);
      len = (k == 0) ? 80 : int'($urandom_range(120, 1));
      request(base, LW'(len));
      wait_idle(20000, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL random_timeout[%0d] got busy=%b required 0", k, busy); end
      n_vec++;
      if (got_q.size() != len) begin
        n_err++;
        $display("FAIL random_count[%0d] got %0d required %0d", k, got_q.size(), len);
      end
      for (int i = 0; i < len; i++) begin
        exp_w = word_of(base + AW'(i));
        act = (i < got_q.size()) ? got_q[i] : 'x;
        n_vec++;
        if (act !== exp_w) begin
          n_err++;
          $display("FAIL random_word[%0d][%0d] got %h required %h", k, i, act, exp_w);
        end
      end
      n_vec++;
      if (max_out > 16) begin
        n_err++;
        $display("FAIL random_credit[%0d] got %0d outstanding required <= 16", k, max_out);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int n_old;
    logic [DW-1:0] act, exp_w;
    clear_mon();
    lat_min = 5; lat_max = 5; ready_pct = 100;
    request(23'h001000, 9'd80);
    wait_words(20, 2000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL abort_first20 got %0d words required 20", got_q.size()); end
    // Second request lands in the flush window and must replace the first pending one.
    @(posedge clk); #1;
    rd_request = 1'b1; rd_address = 23'h003000; rd_burst_length = 9'd7;
    @(posedge clk); #1;
    rd_address = 23'h002000; rd_burst_length = 9'd10;
    @(posedge clk); #1;
    rd_request = 1'b0;
    wait_idle(3000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL abort_timeout got busy=%b required 0", busy); end
    n_old = 0;
    for (int i = 0; i < got_q.size() && i < 80; i++) begin
      if (got_q[i] === word_of(23'h001000 + AW'(i))) n_old++;
      else break;
    end
    n_vec++;
    if (n_old < 20 || n_old > 21) begin
      n_err++;
      $display("FAIL abort_old_words got %0d required 20 or 21", n_old);
    end
    n_vec++;
    if (got_q.size() != n_old + 10) begin
      n_err++;
      $display("FAIL abort_total got %0d required %0d", got_q.size(), n_old + 10);
    end
    for (int i = 0; i < 10; i++) begin
      exp_w = word_of(23'h002000 + AW'(i));
      act = (n_old + i < got_q.size()) ? got_q[n_old + i] : 'x;
      n_vec++;
      if (act !== exp_w) begin
        n_err++;
        $display("FAIL abort_new_word[%0d] got %h required %h", i, act, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [DW-1:0] act, exp_w;
    clear_mon();
    lat_min = 1; lat_max = 6; ready_pct = 100;
    request(AW'($urandom), 9'd80);
    wait_words(30, 2000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rstmid_first30 got %0d words required 30", got_q.size()); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({rd_available, busy, mem_request, mem_address, rd_data} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs got avail=%b busy=%b req=%b addr=%h data=%h required all 0",
               rd_available, busy, mem_request, mem_address, rd_data);
    end
    clear_mon();
    request(23'h000500, 9'd5);
    wait_idle(1000, ok);
    n_vec++;
    if (!ok || got_q.size() != 5) begin
      n_err++;
      $display("FAIL rstmid_count got %0d words busy=%b required 5 and 0", got_q.size(), busy);
    end
    for (int i = 0; i < 5; i++) begin
      exp_w = word_of(23'h000500 + AW'(i));
      act = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (act !== exp_w) begin
        n_err++;
        $display("FAIL rstmid_word[%0d] got %h required %h", i, act, exp_w);
      end
    end
  endtask

  task automatic test_len0();
    clear_mon();
    request(AW'($urandom), 9'd0);
    repeat (10) @(negedge clk);
    n_vec++;
    if (saw_req || saw_avail || saw_busy) begin
      n_err++;
      $display("FAIL len0_quiet got req=%b avail=%b busy=%b required 0 0 0",
               saw_req, saw_avail, saw_busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_abort();
    test_reset_mid();
    test_len0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
